amt_commit_repair: RTL and testbench

Commit-side architectural map table (AMT) and repair sequencer; the producer of the freed-register and RMT-repair streams that rename consumes. On each retiring instruction with a valid destination, it returns the previously committed physical register to the speculative free list and records the new committed mapping. On a recovery request, it walks the AMT and streams `N_REPAIR` (logical, physical) pairs per cycle so the rename map table can be rebuilt.

---
 rtl/amt_commit_repair_pkg.sv | 32 +++
 rtl/amt_commit_repair_amt_ram.sv | 42 ++++
 rtl/amt_commit_repair.sv | 153 +++++++++++++++
 tb/tb_amt_commit_repair.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/amt_commit_repair_pkg.sv
// Shared widths, payload types and repair-state encoding for the commit-side
// architectural map table and its RMT repair sequencer.
package amt_commit_repair_pkg;

   localparam int unsigned COMMIT_WIDTH = 4;
   localparam int unsigned LOG_REGS     = 64;
   localparam int unsigned PHYS_REGS    = 128;
   localparam int unsigned N_REPAIR     = 4;

   localparam int unsigned LOG_W        = $clog2(LOG_REGS);
   localparam int unsigned PHYS_W       = $clog2(PHYS_REGS);
   localparam int unsigned WALK_CYCLES  = LOG_REGS / N_REPAIR;
   localparam int unsigned CNT_W        = $clog2(WALK_CYCLES);
   // AMT read ports: one per commit lane for freeing, one per repair packet
   localparam int unsigned N_RD         = COMMIT_WIDTH + N_REPAIR;

   typedef struct packed {
      logic              valid;
      logic [PHYS_W-1:0] regId;
   } physReg_t;

   typedef struct packed {
      logic             valid;
      logic [LOG_W-1:0] regId;
   } logReg_t;

   typedef enum logic {
      IDLE   = 1'b0,
      REPAIR = 1'b1
   } repairState_t;

endpackage

// File: rtl/amt_commit_repair_amt_ram.sv
// Architectural map table storage: LOG_REGS x PHYS_W entries.
// Ports: clk, reset (async, active-low, loads identity map);
//        wrEn/wrAddr/wrData: COMMIT_WIDTH write ports, highest lane wins;
//        rdAddr/rdData: N_RD combinational read ports (pre-write contents).
module amt_commit_repair_amt_ram
   import amt_commit_repair_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [COMMIT_WIDTH-1:0]              wrEn,
   input  logic [COMMIT_WIDTH-1:0][LOG_W-1:0]   wrAddr,
   input  logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]  wrData,
   input  logic [N_RD-1:0][LOG_W-1:0]           rdAddr,
   output logic [N_RD-1:0][PHYS_W-1:0]          rdData
);

   logic [PHYS_W-1:0] mem [LOG_REGS];

   // Later lanes are issued last so their write takes effect on a collision
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LOG_REGS; i++) begin
            mem[i] <= PHYS_W'(i);
         end
      end else begin
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (wrEn[k]) begin
               mem[wrAddr[k]] <= wrData[k];
            end
         end
      end
   end

   // Combinational read ports
   always_comb begin
      rdData = '0;
      for (int r = 0; r < N_RD; r++) begin
         rdData[r] = mem[rdAddr[r]];
      end
   end

endmodule

// File: rtl/amt_commit_repair.sv
// Commit-side AMT plus repair sequencer. Retiring writers return the previous
// committed mapping to the free list; a recovery walks the AMT and streams
// N_REPAIR (logical, physical) pairs per cycle to rebuild the rename map.
// Ports: clk, reset (async, active-low);
//        commitValid_i/commitLogDest_i/commitLogDestValid_i/commitPhyDest_i: retire lanes;
//        recoverFlag_i: start (or restart) a repair walk;
//        freedPhyReg_o: registers freed by last cycle's commits;
//        repairFlag_o/repairAddr_o/repairData_o: repair packets;
//        repairBusy_o: walk in progress; repairDone_o: pulse after last packet.
module amt_commit_repair
   import amt_commit_repair_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [COMMIT_WIDTH-1:0]              commitValid_i,
   input  logic [COMMIT_WIDTH-1:0][LOG_W-1:0]   commitLogDest_i,
   input  logic [COMMIT_WIDTH-1:0]              commitLogDestValid_i,
   input  logic [COMMIT_WIDTH-1:0][PHYS_W-1:0]  commitPhyDest_i,
   input  logic                                 recoverFlag_i,
   output physReg_t [COMMIT_WIDTH-1:0]          freedPhyReg_o,
   output logic                                 repairFlag_o,
   output logic [N_REPAIR-1:0][LOG_W-1:0]       repairAddr_o,
   output logic [N_REPAIR-1:0][PHYS_W-1:0]      repairData_o,
   output logic                                 repairBusy_o,
   output logic                                 repairDone_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WALK_CYCLES - 1);

   repairState_t                      state, stateNext;
   logic [CNT_W-1:0]                  walkCnt, walkCntNext, readIdx;
   logic                              busyNext, doneNext;
   logic [COMMIT_WIDTH-1:0]           commitAct;
   logic [N_RD-1:0][LOG_W-1:0]        rdAddr;
   logic [N_RD-1:0][PHYS_W-1:0]       rdData;
   logic [N_REPAIR-1:0][LOG_W-1:0]    walkAddr;
   logic [N_REPAIR-1:0][PHYS_W-1:0]   walkData;
   physReg_t [COMMIT_WIDTH-1:0]       freedNext;

   // Commits arriving during a walk are illegal and dropped
   assign commitAct = commitValid_i & commitLogDestValid_i
                    & {COMMIT_WIDTH{state == IDLE}};

   amt_commit_repair_amt_ram amtRam (
      .clk    (clk),
      .reset  (reset),
      .wrEn   (commitAct),
      .wrAddr (commitLogDest_i),
      .wrData (commitPhyDest_i),
      .rdAddr (rdAddr),
      .rdData (rdData)
   );

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         walkCnt <= '0;
      end else begin
         state   <= stateNext;
         walkCnt <= walkCntNext;
      end
   end

   // Next state; readIdx is the packet index presented next cycle
   always_comb begin
      stateNext   = state;
      walkCntNext = walkCnt;
      readIdx     = '0;
      doneNext    = 1'b0;
      if (recoverFlag_i) begin
         stateNext   = REPAIR;
         walkCntNext = '0;
      end else begin
         case (state)
            REPAIR: begin
               if (walkCnt == LAST_CNT) begin
                  stateNext = IDLE;
                  doneNext  = 1'b1;
               end else begin
                  walkCntNext = walkCnt + CNT_W'(1);
                  readIdx     = walkCnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
      busyNext = (stateNext == REPAIR);
   end

   // AMT read addresses: commit lanes first, then the walk packets
   always_comb begin
      rdAddr   = '0;
      walkAddr = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         rdAddr[k] = commitLogDest_i[k];
      end
      for (int p = 0; p < N_REPAIR; p++) begin
         walkAddr[p] = LOG_W'(readIdx) * LOG_W'(N_REPAIR) + LOG_W'(p);
         rdAddr[COMMIT_WIDTH + p] = walkAddr[p];
      end
   end

   // Walk data bypasses this cycle's commits so a commit alongside recovery is seen
   always_comb begin
      walkData = '0;
      for (int p = 0; p < N_REPAIR; p++) begin
         walkData[p] = rdData[COMMIT_WIDTH + p];
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (commitAct[k] && (commitLogDest_i[k] == walkAddr[p])) begin
               walkData[p] = commitPhyDest_i[k];
            end
         end
      end
   end

   // Freed register: nearest older lane in the group with the same dest, else AMT
   always_comb begin
      freedNext = '0;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (commitAct[k]) begin
            freedNext[k].valid = 1'b1;
            freedNext[k].regId = rdData[k];
            for (int j = 0; j < COMMIT_WIDTH; j++) begin
               if ((j < k) && commitAct[j]
                   && (commitLogDest_i[j] == commitLogDest_i[k])) begin
                  freedNext[k].regId = commitPhyDest_i[j];
               end
            end
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         freedPhyReg_o <= '0;
         repairFlag_o  <= 1'b0;
         repairBusy_o  <= 1'b0;
         repairDone_o  <= 1'b0;
         repairAddr_o  <= '0;
         repairData_o  <= '0;
      end else begin
         freedPhyReg_o <= freedNext;
         repairFlag_o  <= busyNext;
         repairBusy_o  <= busyNext;
         repairDone_o  <= doneNext;
         repairAddr_o  <= busyNext ? walkAddr : '0;
         repairData_o  <= busyNext ? walkData : '0;
      end
   end

endmodule

// File: tb/tb_amt_commit_repair.sv
// Testbench for amt_commit_repair: directed scenarios with literal
// expectations, then randomized commit/recover traffic against a
// behavioural model compared every cycle.
module tb_amt_commit_repair;
   import amt_commit_repair_pkg::*;

   logic                                clk = 1'b0;
   logic                                reset = 1'b0;
   logic [COMMIT_WIDTH-1:0]             commitValid = '0;
   logic [COMMIT_WIDTH-1:0][LOG_W-1:0]  commitLogDest = '0;
   logic [COMMIT_WIDTH-1:0]             commitLogDestValid = '0;
   logic [COMMIT_WIDTH-1:0][PHYS_W-1:0] commitPhyDest = '0;
   logic                                recoverFlag = 1'b0;
   physReg_t [COMMIT_WIDTH-1:0]         freedPhyReg;
   logic                                repairFlag;
   logic [N_REPAIR-1:0][LOG_W-1:0]      repairAddr;
   logic [N_REPAIR-1:0][PHYS_W-1:0]     repairData;
   logic                                repairBusy;
   logic                                repairDone;

   int nChecks = 0;
   int nErrors = 0;

   amt_commit_repair dut (
      .clk                  (clk),
      .reset                (reset),
      .commitValid_i        (commitValid),
      .commitLogDest_i      (commitLogDest),
      .commitLogDestValid_i (commitLogDestValid),
      .commitPhyDest_i      (commitPhyDest),
      .recoverFlag_i        (recoverFlag),
      .freedPhyReg_o        (freedPhyReg),
      .repairFlag_o         (repairFlag),
      .repairAddr_o         (repairAddr),
      .repairData_o         (repairData),
      .repairBusy_o         (repairBusy),
      .repairDone_o         (repairDone)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         if (nErrors <= 40) $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Sequential retire semantics over a copy of the map; repair is a pure
   // function of the edge distance from the most recent recovery.
   int amtM [LOG_REGS];
   int snapM[LOG_REGS];
   int tmpM [LOG_REGS];
   int edgeN = 0;
   int recEdge = -1000;
   int dM;
   bit accM;
   logic expBusy = 1'b0;
   logic expDone = 1'b0;
   physReg_t [COMMIT_WIDTH-1:0]         expFreed = '0;
   logic [N_REPAIR-1:0][LOG_W-1:0]      expAddr = '0;
   logic [N_REPAIR-1:0][PHYS_W-1:0]     expData = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LOG_REGS; i++) begin amtM[i] = i; snapM[i] = i; end
         recEdge  = -1000;
         expBusy  = 1'b0;
         expDone  = 1'b0;
         expFreed = '0;
         expAddr  = '0;
         expData  = '0;
      end else begin
         edgeN++;
         dM   = edgeN - 1 - recEdge;
         accM = !(dM >= 0 && dM < int'(WALK_CYCLES));
         tmpM = amtM;
         for (int k = 0; k < COMMIT_WIDTH; k++) begin
            expFreed[k] = '0;
            if (accM && commitValid[k] && commitLogDestValid[k]) begin
               expFreed[k].valid = 1'b1;
               expFreed[k].regId = PHYS_W'(tmpM[commitLogDest[k]]);
               tmpM[commitLogDest[k]] = int'(commitPhyDest[k]);
            end
         end
         amtM = tmpM;
         if (recoverFlag) begin
            recEdge = edgeN;
            snapM   = amtM;
         end
         dM      = edgeN - recEdge;
         expBusy = (dM >= 0 && dM < int'(WALK_CYCLES));
         expDone = (dM == int'(WALK_CYCLES));
         for (int p = 0; p < N_REPAIR; p++) begin
            expAddr[p] = expBusy ? LOG_W'(dM * int'(N_REPAIR) + p) : '0;
            expData[p] = expBusy ? PHYS_W'(snapM[dM * int'(N_REPAIR) + p]) : '0;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      for (int k = 0; k < COMMIT_WIDTH; k++) chk($sformatf("freed%0d", k), freedPhyReg[k], expFreed[k]);
      chk("busy", repairBusy, expBusy);
      chk("flag", repairFlag, expBusy);
      chk("done", repairDone, expDone);
      chk("addr", repairAddr, expAddr);
      chk("data", repairData, expData);
      chk("legalStim", commitValid & {COMMIT_WIDTH{repairBusy}}, '0);
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearIn();
      commitValid        = '0;
      commitLogDestValid = '0;
      commitLogDest      = '0;
      commitPhyDest      = '0;
      recoverFlag        = 1'b0;
   endtask

   task automatic setLane(input int k, input int ld, input int pd);
      commitValid[k]        = 1'b1;
      commitLogDestValid[k] = 1'b1;
      commitLogDest[k]      = LOG_W'(ld);
      commitPhyDest[k]      = PHYS_W'(pd);
   endtask

   // Observe a walk whose recovery edge just passed
   task automatic walkObserve(input int addrX, input int dataX, input bit ident, input int freedX);
      int a;
      for (int c = 0; c < WALK_CYCLES; c++) begin
         @(negedge clk);
         if (c == 0 && freedX >= 0) begin
            chk("lit_freed0_valid", freedPhyReg[0].valid, 1);
            chk("lit_freed0_reg", freedPhyReg[0].regId, freedX);
         end
         if (c == 0) chk("lit_busy_start", repairBusy, 1);
         for (int p = 0; p < N_REPAIR; p++) begin
            a = c * int'(N_REPAIR) + p;
            chk("lit_addr", repairAddr[p], a);
            if (ident) chk("lit_data_ident", repairData[p], a);
            else if (a == addrX) chk("lit_data", repairData[p], dataX);
         end
      end
      @(negedge clk);
      chk("lit_done", repairDone, 1);
      chk("lit_busy_end", repairBusy, 0);
   endtask

   task automatic walkCheck(input int addrX, input int dataX, input bit ident);
      recoverFlag = 1'b1;
      tick();
      clearIn();
      walkObserve(addrX, dataX, ident, -1);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int doneCnt, doneAt;
      clearIn();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_freed", freedPhyReg, '0);
      chk("rst_busy", repairBusy, 0);
      chk("rst_flag", repairFlag, 0);
      chk("rst_done", repairDone, 0);
      chk("rst_addr", repairAddr, '0);
      chk("rst_data", repairData, '0);
      reset = 1'b1;

      // Walk after reset: identity map
      walkCheck(0, 0, 1'b1);

      // Single commit r5 -> p70
      setLane(0, 5, 70);
      tick();
      clearIn();
      @(negedge clk);
      chk("lit_r5_valid", freedPhyReg[0].valid, 1);
      chk("lit_r5_freed", freedPhyReg[0].regId, 5);
      chk("lit_r5_lane1", freedPhyReg[1], '0);
      walkCheck(5, 70, 1'b0);

      // Intra-group forwarding on r3
      setLane(0, 3, 80);
      setLane(2, 3, 81);
      tick();
      clearIn();
      @(negedge clk);
      chk("lit_grp_freed0", freedPhyReg[0].regId, 3);
      chk("lit_grp_freed2", freedPhyReg[2].regId, 80);
      chk("lit_grp_valid2", freedPhyReg[2].valid, 1);
      chk("lit_grp_lane1", freedPhyReg[1].valid, 0);
      walkCheck(3, 81, 1'b0);

      // Commit in the recovery cycle
      setLane(0, 7, 90);
      recoverFlag = 1'b1;
      tick();
      clearIn();
      walkObserve(7, 90, 1'b0, 7);

      // Restart mid-walk: one done, 16 cycles after the restart edge
      recoverFlag = 1'b1;
      tick();
      clearIn();
      doneCnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (repairDone) doneCnt++;
      end
      recoverFlag = 1'b1;
      tick();
      clearIn();
      doneAt = -1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (i == 0) chk("lit_restart_addr0", repairAddr[0], 0);
         if (repairDone) begin doneCnt++; doneAt = i; end
      end
      chk("lit_restart_doneCnt", doneCnt, 1);
      chk("lit_restart_doneAt", doneAt, 16);

      // Reset mid-walk
      recoverFlag = 1'b1;
      tick();
      clearIn();
      repeat (8) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("lit_rstmid_busy", repairBusy, 0);
      chk("lit_rstmid_flag", repairFlag, 0);
      chk("lit_rstmid_addr", repairAddr, '0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      walkCheck(0, 0, 1'b1);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         clearIn();
         if (!expBusy) begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
               commitValid[k]        = ($urandom_range(0, 2) != 0);
               commitLogDestValid[k] = ($urandom_range(0, 3) != 0);
               commitLogDest[k]      = ($urandom_range(0, 1) != 0) ? LOG_W'($urandom_range(0, 7))
                                                                   : LOG_W'($urandom_range(0, 63));
               commitPhyDest[k]      = PHYS_W'($urandom_range(0, 127));
            end
         end
         recoverFlag = ($urandom_range(0, 29) == 0);
         tick();
      end
      clearIn();
      repeat (20) tick();

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
